// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue unit: ALU control codes, RV32I opcodes,
// sequencer state and the operand/class selectors produced by the decoder.
package alu_issue_unit_pkg;

    localparam logic [3:0] ALU_IDLE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_e;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_PC_INC} b_sel_e;
    typedef enum logic [2:0] {CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILLEGAL} op_class_e;

    // Register/immediate arithmetic share one funct3 map; only the register form may subtract.
    function automatic logic [3:0] alu_code_for_f3(input logic [2:0] f3, input logic b5, input logic sub_ok);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (sub_ok && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Bundle of the decode-side handshake, the shared ALU operand/result bus and
// the writeback-side result packet. The unit attaches through the slave modport.
interface alu_issue_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_b5;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_branch_taken;
    logic [31:0] out_target;
    logic        out_illegal;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7_b5, in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd,
        input  in_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero,
        input  out_valid, out_result, out_rd, out_wb_en, out_branch_taken, out_target, out_illegal,
        output out_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7_b5, in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd,
        output in_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero,
        output out_valid, out_result, out_rd, out_wb_en, out_branch_taken, out_target, out_illegal,
        input  out_ready
    );
endinterface

// File: rtl/alu_issue_unit_alu_op_decode.sv
// Combinational instruction classifier: picks the ALU code, operand sources
// and the instruction class that later decides writeback and branch handling.
module alu_op_decode
    import alu_issue_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_control,
    output a_sel_e     a_sel,
    output b_sel_e     b_sel,
    output op_class_e  op_class
);

    // Anything not recognised falls through as illegal with the ALU left idle.
    always_comb begin
        alu_control = ALU_IDLE;
        a_sel       = A_RS1;
        b_sel       = B_RS2;
        op_class    = CLS_ILLEGAL;
        case (opcode)
            OPC_OP: begin
                alu_control = alu_code_for_f3(funct3, funct7_b5, 1'b1);
                op_class    = CLS_ALU;
            end
            OPC_OP_IMM: begin
                alu_control = alu_code_for_f3(funct3, funct7_b5, 1'b0);
                b_sel       = B_IMM;
                op_class    = CLS_ALU;
            end
            OPC_LOAD, OPC_STORE: begin
                alu_control = ALU_ADD;
                b_sel       = B_IMM;
                op_class    = (opcode == OPC_LOAD) ? CLS_LOAD : CLS_STORE;
            end
            OPC_LUI, OPC_AUIPC: begin
                alu_control = ALU_ADD;
                a_sel       = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                b_sel       = B_IMM;
                op_class    = CLS_ALU;
            end
            OPC_JAL: begin
                alu_control = ALU_ADD;
                a_sel       = A_PC;
                b_sel       = B_PC_INC;
                op_class    = CLS_JAL;
            end
            OPC_BRANCH: begin
                op_class = CLS_BRANCH;
                case (funct3)
                    3'b000, 3'b001: alu_control = ALU_SUB;
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        op_class    = CLS_ILLEGAL;
                endcase
            end
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Execute-stage sequencer: accepts a decoded instruction, drives the shared ALU
// for one cycle, then holds a registered result packet until writeback takes it.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [31:0] PC_INC = 32'd4
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_unit_if.slave  bus
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    op_class_e       cls_q, cls_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_wb_en_q, out_wb_en_d;
    logic            out_taken_q, out_taken_d;
    logic [XLEN-1:0] out_target_q, out_target_d;
    logic            out_illegal_q, out_illegal_d;

    logic      in_ready;
    logic      accept;
    logic [3:0] dec_ctrl;
    a_sel_e    dec_a_sel;
    b_sel_e    dec_b_sel;
    op_class_e dec_class;
    logic [XLEN-1:0] a_val, b_val;

    alu_op_decode u_decode (
        .opcode      (bus.in_opcode),
        .funct3      (bus.in_funct3),
        .funct7_b5   (bus.in_funct7_b5),
        .alu_control (dec_ctrl),
        .a_sel       (dec_a_sel),
        .b_sel       (dec_b_sel),
        .op_class    (dec_class)
    );

    assign in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    // Next-state, capture and packet formation; ALU operands are only nonzero during EXEC.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = '0;
        alu_b_d       = '0;
        alu_ctrl_d    = ALU_IDLE;
        cls_d         = cls_q;
        f3_d          = f3_q;
        rd_d          = rd_q;
        target_d      = target_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_wb_en_d   = out_wb_en_q;
        out_taken_d   = out_taken_q;
        out_target_d  = out_target_q;
        out_illegal_d = out_illegal_q;

        case (dec_a_sel)
            A_PC:    a_val = bus.in_pc;
            A_ZERO:  a_val = '0;
            default: a_val = bus.in_rs1_val;
        endcase
        case (dec_b_sel)
            B_IMM:    b_val = bus.in_imm;
            B_PC_INC: b_val = PC_INC;
            default:  b_val = bus.in_rs2_val;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                out_valid_d   = 1'b1;
                out_result_d  = bus.alu_result;
                out_rd_d      = rd_q;
                out_illegal_d = (cls_q == CLS_ILLEGAL);
                out_wb_en_d   = (rd_q != 5'd0) &&
                                ((cls_q == CLS_ALU) || (cls_q == CLS_LOAD) || (cls_q == CLS_JAL));
                out_taken_d   = 1'b0;
                out_target_d  = '0;
                if (cls_q == CLS_BRANCH) begin
                    out_target_d = target_q;
                    if (f3_q[2]) out_taken_d = bus.alu_result[0] ^ f3_q[0];
                    else         out_taken_d = bus.alu_zero ^ f3_q[0];
                end else if (cls_q == CLS_JAL) begin
                    out_target_d = target_q;
                    out_taken_d  = 1'b1;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            alu_a_d    = a_val;
            alu_b_d    = b_val;
            alu_ctrl_d = dec_ctrl;
            cls_d      = dec_class;
            f3_d       = bus.in_funct3;
            rd_d       = bus.in_rd;
            target_d   = bus.in_pc + bus.in_imm;
        end
    end

    // Single state register; a low rst_n at the edge drops any in-flight instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= ALU_IDLE;
            cls_q         <= CLS_ALU;
            f3_q          <= '0;
            rd_q          <= '0;
            target_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_wb_en_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_target_q  <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            cls_q         <= cls_d;
            f3_q          <= f3_d;
            rd_q          <= rd_d;
            target_q      <= target_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_wb_en_q   <= out_wb_en_d;
            out_taken_q   <= out_taken_d;
            out_target_q  <= out_target_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.alu_a            = alu_a_q;
    assign bus.alu_b            = alu_b_q;
    assign bus.alu_control      = alu_ctrl_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_result       = out_result_q;
    assign bus.out_rd           = out_rd_q;
    assign bus.out_wb_en        = out_wb_en_q;
    assign bus.out_branch_taken = out_taken_q;
    assign bus.out_target       = out_target_q;
    assign bus.out_illegal      = out_illegal_q;

endmodule
